// File: rtl/quadra_pipe_if.sv
// Bundle of data/handshake/config signals for quadra_pipe.
// Valid/ready: a beat moves on a rising clk edge where both valid and ready are high; the source holds data stable while valid is high and ready is low.
interface quadra_pipe_if #(
  parameter int XW = 16,
  parameter int CW = 16,
  parameter int OW = 32
) ();
  logic signed [XW-1:0] x;
  logic                 x_dv;
  logic                 x_rdy;
  logic signed [OW-1:0] y;
  logic                 y_dv;
  logic                 y_rdy;
  logic                 y_ovf;
  logic                 cfg_we;
  logic signed [CW-1:0] cfg_a;
  logic signed [CW-1:0] cfg_b;
  logic signed [CW-1:0] cfg_c;
  logic                 cfg_busy;

  modport master (
    output x, x_dv, y_rdy, cfg_we, cfg_a, cfg_b, cfg_c,
    input  x_rdy, y, y_dv, y_ovf, cfg_busy
  );

  modport slave (
    input  x, x_dv, y_rdy, cfg_we, cfg_a, cfg_b, cfg_c,
    output x_rdy, y, y_dv, y_ovf, cfg_busy
  );
endinterface

// File: rtl/quadra_pipe.sv
// Pipelined y = A*x^2 + B*x + C with programmable coefficients and ready/valid on both sides.
// Define QUADRA_SAT_EN to saturate the result to OW bits and flag y_ovf; otherwise the result wraps.
module quadra_pipe #(
  parameter int XW = 16,
  parameter int CW = 16,
  parameter int OW = 32
) (
  input  logic       clk,
  input  logic       rst_b,
  quadra_pipe_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam int YW  = 2*XW + CW + 2;
  localparam int XXW = 2*XW;
  localparam int BXW = CW + XW;
  localparam int AXW = CW + 2*XW;
  localparam int BCW = CW + XW + 1;

  localparam logic signed [CW-1:0] A_RST = CW'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic signed [CW-1:0] a_act, b_act, c_act;
  logic signed [CW-1:0] a_shd, b_shd, c_shd;

  logic s0_v, s1_v, y_dv_q;
  logic stall, advance, x_rdy, take, busy;

  logic signed [XXW-1:0] xx_q;
  logic signed [BXW-1:0] bx_q;
  logic signed [AXW-1:0] axx_q;
  logic signed [BCW-1:0] bxc_q;
  logic signed [OW-1:0]  y_q;
  logic                  ovf_q;

  logic signed [XXW-1:0] x_xx, xx_d;
  logic signed [BXW-1:0] x_bx, b_bx, bx_d;
  logic signed [AXW-1:0] a_ax, xx_ax, axx_d;
  logic signed [BCW-1:0] bxc_d;
  logic signed [YW-1:0]  sum_d;
  logic signed [OW-1:0]  y_d;
  logic                  ovf_d;

  // Operands are sign-extended to the product width so every multiply is exact.
  assign x_xx  = {{XW{bus.x[XW-1]}}, bus.x};
  assign xx_d  = x_xx * x_xx;
  assign x_bx  = {{CW{bus.x[XW-1]}}, bus.x};
  assign b_bx  = {{XW{b_act[CW-1]}}, b_act};
  assign bx_d  = b_bx * x_bx;

  assign a_ax  = {{(2*XW){a_act[CW-1]}}, a_act};
  assign xx_ax = {{CW{xx_q[XXW-1]}}, xx_q};
  assign axx_d = a_ax * xx_ax;
  assign bxc_d = {bx_q[BXW-1], bx_q} + {{(XW+1){c_act[CW-1]}}, c_act};

  assign sum_d = {{(YW-AXW){axx_q[AXW-1]}}, axx_q}
               + {{(YW-BCW){bxc_q[BCW-1]}}, bxc_q};

`ifdef QUADRA_SAT_EN
  logic hi_same;
  // The result fits OW bits exactly when all bits from OW-1 upward agree.
  assign hi_same = (&sum_d[YW-1:OW-1]) | ~(|sum_d[YW-1:OW-1]);
  assign y_d     = hi_same ? sum_d[OW-1:0]
                 : (sum_d[YW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
  assign ovf_d   = ~hi_same;
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum_d[YW-1:OW];
  assign y_d           = sum_d[OW-1:0];
  assign ovf_d         = 1'b0;
`endif

  always_comb begin
    stall    = y_dv_q && !bus.y_rdy;
    advance  = !stall;
    x_rdy    = (state == RUN) && !stall;
    take     = bus.x_dv && x_rdy;
    busy     = (state != RUN);
    state_nx = state;
    case (state)
      RUN:     if (bus.cfg_we) state_nx = DRAIN;
      // Commit only once the last result has left, so no sample sees mixed coefficients.
      DRAIN:   if (!s0_v && !s1_v && !y_dv_q) state_nx = COMMIT;
      COMMIT:  state_nx = bus.cfg_we ? DRAIN : RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      a_act <= A_RST;
      b_act <= '0;
      c_act <= '0;
      a_shd <= A_RST;
      b_shd <= '0;
      c_shd <= '0;
    end else begin
      if (bus.cfg_we) begin
        a_shd <= bus.cfg_a;
        b_shd <= bus.cfg_b;
        c_shd <= bus.cfg_c;
      end
      if (state == COMMIT) begin
        a_act <= a_shd;
        b_act <= b_shd;
        c_act <= c_shd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      s0_v   <= 1'b0;
      s1_v   <= 1'b0;
      y_dv_q <= 1'b0;
      xx_q   <= '0;
      bx_q   <= '0;
      axx_q  <= '0;
      bxc_q  <= '0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      s0_v   <= take;
      s1_v   <= s0_v;
      y_dv_q <= s1_v;
      if (take) begin
        xx_q <= xx_d;
        bx_q <= bx_d;
      end
      if (s0_v) begin
        axx_q <= axx_d;
        bxc_q <= bxc_d;
      end
      if (s1_v) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.x_rdy    = x_rdy;
  assign bus.y        = y_q;
  assign bus.y_dv     = y_dv_q;
  assign bus.y_ovf    = ovf_q;
  assign bus.cfg_busy = busy;
  assign state_dbg    = state;

endmodule
